sensor_period_meter: RTL

- Consumes the 8-bit parallel words produced each CLK cycle by the DDR input deserializer, which is fed by the theremin oscillator pin and clocked at 200 MHz.
- Detects rising edges of the oscillator signal at 1/8-cycle resolution, with 0.625 ns per sample.
- Outputs the oscillator period, measured edge to edge, in sample units, with a valid strobe.
- Rejects glitches and reports loss of signal.
- Sits directly downstream of the deserializer and upstream of the pitch/volume filtering logic.

---
 rtl/sensor_period_meter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sensor_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sensor_period_meter
// Description : Measures the theremin oscillator period from 8-sample words
//               delivered by the DDR deserializer. Rising edges are located
//               at single-sample resolution and timestamped. The period is
//               the edge-to-edge distance in samples. Close edges are
//               rejected as glitches, and loss of signal is reported.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_period_meter #(
    parameter int COUNTER_BITS   = 16,
    parameter int MIN_PERIOD     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [7:0]              IN,
    output logic [COUNTER_BITS+2:0] PERIOD,
    output logic                    PERIOD_VALID,
    output logic                    LOCKED,
    output logic                    TIMEOUT
);

    localparam int c_TS_W = COUNTER_BITS + 3;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    localparam logic [COUNTER_BITS-1:0] c_TIMEOUT  = COUNTER_BITS'(TIMEOUT_CYCLES);
    localparam logic [COUNTER_BITS-1:0] c_TO_LAST  = COUNTER_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TS_W-1:0]       c_MIN_PER  = c_TS_W'(MIN_PERIOD);

    // Stage 1 registers
    logic [7:0]              r_s1_word;
    logic                    r_s1_prev;
    logic                    r_last_bit;

    // Stage 2 registers
    logic                    r_s2_found;
    logic [c_TS_W-1:0]       r_s2_ts;

    // Stage 3 / control registers
    logic [COUNTER_BITS-1:0] r_cyc_cnt;
    logic [COUNTER_BITS-1:0] r_elapsed;
    logic [c_TS_W-1:0]       r_ts_ref;
    logic [1:0]              r_state;

    // Combinational
    logic [7:0]              w_edge_vec;
    logic                    w_found;
    logic [2:0]              w_k;
    logic [c_TS_W-1:0]       w_period;
    logic                    w_long_enough;
    logic                    w_timeout_hit;

    // Stage 1: capture the word and the last sample of the word before it.
    // r_last_bit resets to 1 so the first word after reset cannot look like
    // it follows a low sample.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s1_word  <= '0;
            r_s1_prev  <= 1'b1;
            r_last_bit <= 1'b1;
        end else begin
            r_s1_word  <= IN;
            r_s1_prev  <= r_last_bit;
            r_last_bit <= IN[0];
        end
    end

    // Rising edge at sample k: sample k high and sample k-1 low.
    // Sample k lives at bit 7-k, so the earlier sample is one bit up.
    for (genvar k = 0; k < 8; k++) begin : g_edge
        if (k == 0) begin : g_first
            assign w_edge_vec[0] = r_s1_word[7] & ~r_s1_prev;
        end else begin : g_rest
            assign w_edge_vec[k] = r_s1_word[7-k] & ~r_s1_word[8-k];
        end
    end

    // Priority encoder: the earliest edge in the word wins.
    always_comb begin
        w_found = 1'b0;
        w_k     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_edge_vec[k]) begin
                w_found = 1'b1;
                w_k     = 3'(k);
            end
        end
    end

    // Free-running coarse time base; wrap is harmless because periods are
    // taken modulo the timestamp width.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cyc_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
        end
    end

    // Stage 2: register edge presence and its fine timestamp.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_s2_found <= 1'b0;
            r_s2_ts    <= '0;
        end else begin
            r_s2_found <= w_found;
            r_s2_ts    <= {r_cyc_cnt, w_k};
        end
    end

    assign w_period      = r_s2_ts - r_ts_ref;
    assign w_long_enough = (w_period >= c_MIN_PER);
    assign w_timeout_hit = (r_state != c_ST_IDLE) && (r_elapsed == c_TO_LAST);

    // Stage 3: acceptance, period output, lock and timeout tracking.
    // Timeout has priority; a coincident edge restarts acquisition as a
    // first edge so it never produces a strobe.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= c_ST_IDLE;
            r_elapsed    <= '0;
            r_ts_ref     <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
            TIMEOUT      <= 1'b0;
        end else begin
            PERIOD_VALID <= 1'b0;
            TIMEOUT      <= 1'b0;
            if (r_elapsed != c_TIMEOUT) begin
                r_elapsed <= r_elapsed + 1'b1;
            end

            if (w_timeout_hit) begin
                TIMEOUT <= 1'b1;
                if (r_s2_found) begin
                    r_state   <= c_ST_ARMED;
                    r_ts_ref  <= r_s2_ts;
                    r_elapsed <= '0;
                end else begin
                    r_state <= c_ST_IDLE;
                end
            end else if (r_s2_found) begin
                if (r_state == c_ST_IDLE) begin
                    r_state   <= c_ST_ARMED;
                    r_ts_ref  <= r_s2_ts;
                    r_elapsed <= '0;
                end else if (w_long_enough) begin
                    r_state      <= c_ST_RUN;
                    r_ts_ref     <= r_s2_ts;
                    r_elapsed    <= '0;
                    PERIOD       <= w_period;
                    PERIOD_VALID <= 1'b1;
                end
            end
        end
    end

    // Lock indication follows the RUN state directly.
    assign LOCKED = (r_state == c_ST_RUN);

endmodule
`default_nettype wire
